// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit.
//   - access size encodings (cpu_size)
//   - FSM state encoding (exported on the debug port)
//   - request legality check used by the IDLE state
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    MERGE   = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  // A request is rejected without touching memory when it asks for both a
  // load and a store, uses the reserved size, or is not naturally aligned.
  function automatic logic req_illegal(input logic       re,
                                       input logic       we,
                                       input logic [1:0] size,
                                       input logic [1:0] addr_lo);
    return (re && we) ||
           (size == SZ_RSVD) ||
           (size == SZ_WORD && addr_lo != 2'b00) ||
           (size == SZ_HALF && addr_lo[0]);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus bundle between the datapath, the access unit and the data memory.
//   cpu_* : request from the single-cycle datapath, result back to it
//   mem_* : word-addressed memory with a MemReady handshake
// Handshake: the datapath holds cpu_re/cpu_we and the request fields stable
// while cpu_stall=1; cpu_done pulses for exactly one cycle with cpu_rdata and
// cpu_err valid. On the memory side mem_A/mem_WD are held by the unit, mem_WE
// is a single-cycle strobe, and mem_ready qualifies mem_RD.
// Modports: master = the access unit, slave = datapath + memory side.
interface mem_access_unit_if;
  logic        cpu_re;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] mem_A;
  logic        mem_WE;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;
  logic        mem_ready;

  modport master (
    input  cpu_re, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    input  mem_RD, mem_ready,
    output cpu_rdata, cpu_stall, cpu_done, cpu_err,
    output mem_A, mem_WE, mem_WD
  );

  modport slave (
    output cpu_re, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    output mem_RD, mem_ready,
    input  cpu_rdata, cpu_stall, cpu_done, cpu_err,
    input  mem_A, mem_WE, mem_WD
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane handling, purely combinational.
//   i_size, i_unsigned, i_lane : access size, extension mode, addr[1:0]
//   i_rd_word                  : word read from memory
//   i_cap_word                 : word captured for a read-modify-write
//   i_wdata                    : right-aligned store data (low half used)
//   o_load_data                : extracted and extended load result
//   o_merge_word               : captured word with the addressed lane replaced
module lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_cap_word,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_word
);

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_byte_mask;
  logic [31:0] w_half_mask;
  logic [31:0] w_byte_ins;
  logic [31:0] w_half_ins;

  assign w_byte_sh   = i_rd_word >> {i_lane, 3'b000};
  assign w_half_sh   = i_rd_word >> {i_lane[1], 4'b0000};
  assign w_byte      = w_byte_sh[7:0];
  assign w_half      = w_half_sh[15:0];
  assign w_byte_mask = 32'h0000_00FF << {i_lane, 3'b000};
  assign w_half_mask = 32'h0000_FFFF << {i_lane[1], 4'b0000};
  assign w_byte_ins  = {24'b0, i_wdata[7:0]} << {i_lane, 3'b000};
  assign w_half_ins  = {16'b0, i_wdata} << {i_lane[1], 4'b0000};

  always_comb begin
    o_load_data  = i_rd_word;
    o_merge_word = i_cap_word;
    case (i_size)
      SZ_BYTE: begin
        o_load_data  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        o_merge_word = (i_cap_word & ~w_byte_mask) | w_byte_ins;
      end
      SZ_HALF: begin
        o_load_data  = {{16{~i_unsigned & w_half[15]}}, w_half};
        o_merge_word = (i_cap_word & ~w_half_mask) | w_half_ins;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Processor-side initiator for the data memory. Accepts one load/store from
// the datapath, stalls it until the access finishes, and does read-modify-
// write for byte/half stores.
//   clk, rst    : single clock, synchronous active-high reset
//   io_bus      : cpu_* request/result and mem_* memory bus (master view)
//   o_dbg_state : current FSM state
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 64,  // max RD_WAIT count before aborting
  parameter int CNT_W   = 7    // 2**CNT_W must exceed TIMEOUT
)(
  input  logic                clk,
  input  logic                rst,
  mem_access_unit_if.master   io_bus,
  output state_t              o_dbg_state
);

  state_t      r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] r_addr, r_wd, r_rdata, r_word;
  logic        r_err;

  logic        w_req, w_illegal, w_word_store, w_ready_seen, w_timeout;
  logic [31:0] w_load_data, w_merge_word;

  assign w_req        = io_bus.cpu_re | io_bus.cpu_we;
  assign w_illegal    = req_illegal(io_bus.cpu_re, io_bus.cpu_we,
                                    io_bus.cpu_size, io_bus.cpu_addr[1:0]);
  assign w_word_store = io_bus.cpu_we && (io_bus.cpu_size == SZ_WORD);
  // Count 0 is the first cycle after the address change; a ready still high
  // from the previous access must not be taken as this access's data.
  assign w_ready_seen = (r_cnt != '0) && io_bus.mem_ready;
  assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT));

  lane_align u_lane_align (
    .i_size       (io_bus.cpu_size),
    .i_unsigned   (io_bus.cpu_unsigned),
    .i_lane       (io_bus.cpu_addr[1:0]),
    .i_rd_word    (io_bus.mem_RD),
    .i_cap_word   (r_word),
    .i_wdata      (io_bus.cpu_wdata[15:0]),
    .o_load_data  (w_load_data),
    .o_merge_word (w_merge_word)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_illegal)         w_next = DONE;
          else if (w_word_store) w_next = WRITE;
          else                   w_next = RD_WAIT;
        end
      end
      // Ready has priority over the timeout when both land in one cycle.
      RD_WAIT: begin
        if (w_ready_seen)   w_next = io_bus.cpu_we ? MERGE : DONE;
        else if (w_timeout) w_next = DONE;
      end
      MERGE:   w_next = WRITE;
      WRITE:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wd    <= '0;
      r_rdata <= '0;
      r_word  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_rdata <= '0;
            r_err   <= w_illegal;
            // mem_A only moves on an accepted legal request.
            if (!w_illegal) begin
              r_addr <= {io_bus.cpu_addr[31:2], 2'b00};
              r_cnt  <= '0;
              if (w_word_store) r_wd <= io_bus.cpu_wdata;
            end
          end
        end
        RD_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_ready_seen) begin
            r_word <= io_bus.mem_RD;
            if (!io_bus.cpu_we) r_rdata <= w_load_data;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        MERGE:   r_wd <= w_merge_word;
        default: ;
      endcase
    end
  end

  assign io_bus.cpu_stall = (r_state == RD_WAIT) || (r_state == MERGE) ||
                            (r_state == WRITE) || ((r_state == IDLE) && w_req);
  assign io_bus.cpu_done  = (r_state == DONE);
  assign io_bus.cpu_err   = r_err && (r_state == DONE);
  assign io_bus.cpu_rdata = r_rdata;
  assign io_bus.mem_A     = r_addr;
  assign io_bus.mem_WD    = r_wd;
  // Reset in the WRITE cycle suppresses the strobe so memory is not written.
  assign io_bus.mem_WE    = (r_state == WRITE) && !rst;
  assign o_dbg_state      = r_state;

endmodule
